instr_mem: RTL and testbench

Instruction memory responder for the fetch stage: returns the 64-bit instruction word at the fetch stage's `mem_address` one cycle after it is presented. It also provides a byte-serial loader port so a host or testbench can program the program image before or between runs. It sits between the fetch stage and the external loader. Reads and loads are mutually exclusive.

---
 rtl/instr_mem_pkg.sv | 20 ++
 rtl/sram_1rw.sv | 40 ++++
 rtl/instr_mem.sv | 136 +++++++++++++
 tb/tb_instr_mem.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and default sizing for the instruction memory responder.
package instr_mem_pkg;

    localparam int DEF_DEPTH  = 512;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(DEF_DATA_W);

endpackage

// File: rtl/sram_1rw.sv
// Single-port synchronous array with registered read; reads and writes never overlap.
module sram_1rw
    import instr_mem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;

    assign idx = addr[IDX_W-1:0];

    // Array contents survive reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/instr_mem.sv
// Fetch-side instruction memory with a byte-serial loader; reads are suspended while loading.
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:ADDR_W-1] mem_address,
    output logic [0:DATA_W-1] mem_read_data,
    output logic              mem_read_valid,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [0:7]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              busy,
    output logic              load_overflow
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    state_t            state, state_next;
    logic [ADDR_W-1:0] word_ptr;
    logic [CNT_W-1:0]  byte_cnt;
    logic [DATA_W-1:0] asm_q, asm_next;
    logic [ADDR_W-1:0] addr_i, sram_addr;
    logic [7:0]        byte_i;
    logic [DATA_W-1:0] rdata;
    logic              accept, lane_last, word_we, read_en, start, valid_q;

    // Port vectors are MSB-first at bit 0; internal vectors are conventional [W-1:0].
    assign addr_i    = mem_address;
    assign byte_i    = load_byte;
    assign accept    = load_valid && load_ready;
    assign lane_last = (byte_cnt == CNT_W'(BPW - 1));
    assign word_we   = accept && (lane_last || load_last);
    assign read_en   = (state == ST_IDLE);
    assign start     = (state == ST_IDLE) && load_start;
    assign sram_addr = (state == ST_LOAD) ? word_ptr : addr_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        load_done  = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b1;
                if (load_valid && load_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                load_done  = 1'b1;
                busy       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Lane 0 is the most significant byte, so the first byte lands in port bits [0:7].
    always_comb begin
        asm_next = asm_q;
        asm_next[DATA_W-1-8*int'(byte_cnt) -: 8] = byte_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_ptr      <= '0;
            byte_cnt      <= '0;
            asm_q         <= '0;
            load_overflow <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            valid_q <= read_en;
            if (start) begin
                word_ptr      <= '0;
                byte_cnt      <= '0;
                asm_q         <= '0;
                load_overflow <= 1'b0;
            end else if (accept) begin
                // Clearing after every write keeps unfilled lanes of a partial final word at zero.
                asm_q <= word_we ? '0 : asm_next;
                if (lane_last) begin
                    byte_cnt <= '0;
                    if (word_ptr == ADDR_W'(DEPTH - 1)) begin
                        word_ptr      <= '0;
                        load_overflow <= 1'b1;
                    end else begin
                        word_ptr <= word_ptr + ADDR_W'(1);
                    end
                end else begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end
        end
    end

    sram_1rw #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk   (clk),
        .rst   (rst),
        .we    (word_we),
        .re    (read_en),
        .addr  (sram_addr),
        .wdata (asm_next),
        .rdata (rdata)
    );

    assign mem_read_valid = valid_q;
    assign mem_read_data  = rdata;

endmodule

// File: tb/tb_instr_mem.sv
// Randomized scoreboard bench for instr_mem against a word/byte-level reference model.
module tb_instr_mem;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [0:ADDR_W-1] mem_address;
    logic [0:DATA_W-1] mem_read_data;
    logic              mem_read_valid;
    logic              load_start, load_valid, load_last;
    logic [0:7]        load_byte;
    logic              load_ready, load_done, busy, load_overflow;

    instr_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_address    (mem_address),
        .mem_read_data  (mem_read_data),
        .mem_read_valid (mem_read_valid),
        .load_start     (load_start),
        .load_valid     (load_valid),
        .load_byte      (load_byte),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .load_done      (load_done),
        .busy           (busy),
        .load_overflow  (load_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: 0 = idle, 1 = loading, 2 = done pulse.
    int          ms = 0;
    int          ptr = 0;
    int          cnt = 0;
    logic [63:0] asm_w = '0;
    bit          ovf = 1'b0;
    logic [63:0] ref_mem [DEPTH];
    bit          known   [DEPTH];

    typedef struct {
        int          tag;
        bit          v;
        bit          chk;
        logic [63:0] d;
    } exp_t;
    exp_t sbq[$];

    // Drives one cycle of stimulus, predicts the read response, advances the model.
    task automatic step(input int addr, input bit start, input bit lv, input logic [7:0] lb, input bit ll);
        exp_t e;
        logic [ADDR_W-1:0] a;
        a = addr[ADDR_W-1:0];
        mem_address = a;
        load_start  = start;
        load_valid  = lv;
        load_byte   = lb;
        load_last   = ll;
        e.tag = cyc + 1;
        e.v   = (ms == 0);
        e.chk = e.v && known[addr];
        e.d   = ref_mem[addr];
        sbq.push_back(e);
        @(posedge clk);
        case (ms)
            0: if (start) begin
                ms = 1; ptr = 0; cnt = 0; asm_w = '0; ovf = 1'b0;
            end
            1: if (lv) begin
                asm_w = asm_w | (64'(lb) << (8 * (7 - cnt)));
                cnt++;
                if (cnt == 8 || ll) begin
                    ref_mem[ptr] = asm_w;
                    known[ptr]   = 1'b1;
                    asm_w        = '0;
                end
                if (cnt == 8) begin
                    cnt = 0;
                    if (ptr == DEPTH - 1) begin ptr = 0; ovf = 1'b1; end
                    else ptr++;
                end
                if (ll) ms = 2;
            end
            default: ms = 0;
        endcase
        #1;
        check("busy", busy, 64'(ms != 0));
        check("load_ready", load_ready, 64'(ms == 1));
        check("load_done", load_done, 64'(ms == 2));
        check("load_overflow", load_overflow, 64'(ovf));
    endtask

    task automatic rd(input int addr);
        step(addr, 1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic load_image(input logic [7:0] bytes[$], input int pulse_at, input bit gaps);
        step($urandom_range(DEPTH - 1), 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < bytes.size(); i++) begin
            if (gaps && $urandom_range(3) == 0)
                step($urandom_range(DEPTH - 1), 1'b0, 1'b0, 8'($urandom), 1'b0);
            step($urandom_range(DEPTH - 1), (i == pulse_at), 1'b1, bytes[i], (i == bytes.size() - 1));
        end
        check("done_pulse", load_done, 64'd1);
        rd($urandom_range(DEPTH - 1));
    endtask

    // Monitor: compares each read response against the entry tagged for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                while (sbq.size() > 0 && sbq[0].tag < cyc) begin
                    e = sbq.pop_front();
                    check("sb_stale", 64'(e.tag), 64'(cyc));
                end
                if (sbq.size() > 0 && sbq[0].tag == cyc) begin
                    e = sbq.pop_front();
                    check("rd_valid", mem_read_valid, 64'(e.v));
                    if (e.v && e.chk) check("rd_data", mem_read_data, e.d);
                end else if (mem_read_valid) begin
                    check("rd_unexpected", mem_read_valid, 64'd0);
                end
            end
        end
    end

    initial begin
        logic [7:0]  img[$];
        logic [63:0] old1;
        rst = 1'b1;
        mem_address = '0; load_start = 0; load_valid = 0; load_byte = '0; load_last = 0;
        for (int i = 0; i < DEPTH; i++) begin known[i] = 1'b0; ref_mem[i] = '0; end
        #12;
        check("rst_data", mem_read_data, 64'd0);
        check("rst_valid", mem_read_valid, 64'd0);
        check("rst_busy", {load_ready, load_done, busy, load_overflow}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two full words of ascending bytes.
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(8'(i));
        load_image(img, -1, 1'b0);
        rd(0); check("word0", mem_read_data, 64'h0001020304050607);
        rd(1); check("word1", mem_read_data, 64'h08090A0B0C0D0E0F);

        // Partial final word; word 1 must stay untouched.
        img.delete();
        img.push_back(8'hAA); img.push_back(8'hBB); img.push_back(8'hCC);
        load_image(img, -1, 1'b1);
        rd(0); check("partial0", mem_read_data, 64'hAABBCC0000000000);
        rd(1); check("partial1", mem_read_data, 64'h08090A0B0C0D0E0F);

        rd(1); rd(0); rd(1);
        check("b2b_valid", mem_read_valid, 64'd1);
        for (int i = 0; i < 30; i++) rd($urandom_range(1));

        // load_start pulse mid-load must not restart the pointer.
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
        load_image(img, 10, 1'b1);
        for (int i = 0; i < 3; i++) rd(i);

        // Wrap past the last word.
        img.delete();
        for (int i = 0; i < (DEPTH + 1) * 8; i++) img.push_back(8'($urandom));
        load_image(img, -1, 1'b1);
        check("ovf_set", load_overflow, 64'd1);
        rd(0);
        check("wrap_word0", mem_read_data,
              {img[DEPTH*8], img[DEPTH*8+1], img[DEPTH*8+2], img[DEPTH*8+3],
               img[DEPTH*8+4], img[DEPTH*8+5], img[DEPTH*8+6], img[DEPTH*8+7]});
        for (int i = 0; i < 40; i++) rd($urandom_range(DEPTH - 1));

        // Reset after 5 bytes of the second word.
        old1 = ref_mem[1];
        step(3, 1'b1, 1'b0, 8'h00, 1'b0);
        check("ovf_clear", load_overflow, 64'd0);
        for (int i = 0; i < 13; i++) step($urandom_range(DEPTH - 1), 1'b0, 1'b1, 8'($urandom), 1'b0);
        rst = 1'b1;
        sbq.delete();
        #1;
        check("arst_data", mem_read_data, 64'd0);
        check("arst_valid", mem_read_valid, 64'd0);
        check("arst_flags", {load_ready, load_done, busy, load_overflow}, 64'd0);
        ms = 0; ovf = 1'b0; cnt = 0; asm_w = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        rd(0); check("kept_word0", mem_read_data, ref_mem[0]);
        rd(1); check("kept_word1", mem_read_data, old1);
        for (int i = 0; i < 20; i++) rd($urandom_range(DEPTH - 1));
        rd(0); rd(0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
